// File: rtl/vsync_rx_pkg.sv
// -----------------------------------------------------------------------------
// vsync_rx_pkg
// Shared VGA timing definitions used by the vsync receiver and the vsync
// generator: line counter width, saturation value, pulse-width counter width,
// the receiver FSM state type and small saturating-increment helpers.
// -----------------------------------------------------------------------------
package vsync_rx_pkg;

  localparam int LINE_W = 10;
  localparam logic [LINE_W-1:0] LINE_MAX = 10'd1023;

  localparam int PW_W = 4;
  localparam logic [PW_W-1:0] PW_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCK    = 2'd3
  } vs_state_e;

  // Line counter increment that sticks at LINE_MAX.
  function automatic logic [LINE_W-1:0] line_sat_inc(input logic [LINE_W-1:0] v);
    return (v == LINE_MAX) ? LINE_MAX : v + 10'd1;
  endfunction

  // Pulse-width counter increment that sticks at PW_MAX.
  function automatic logic [PW_W-1:0] pw_sat_inc(input logic [PW_W-1:0] v);
    return (v == PW_MAX) ? PW_MAX : v + 4'd1;
  endfunction

endpackage

// File: rtl/vsync_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous level followed by an edge-detect
// register. Generic so it can serve vsync and hsync alike.
//   clk   : sampling clock
//   reset : asynchronous active-high reset, flops go to RST_VAL
//   d     : asynchronous input
//   level : synchronized level
//   rise  : synchronized level went 0->1 (combinational, one cycle)
//   fall  : synchronized level went 1->0 (combinational, one cycle)
// -----------------------------------------------------------------------------
module sync_edge
  import vsync_rx_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus the previous-level register for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/vsync_rx.sv
// -----------------------------------------------------------------------------
// vsync_rx
// Recovers the line index from an asynchronous vertical sync, measures frame
// length and sync pulse width, and reports lock once LOCK_FRAMES consecutive
// frames have the same length.
//   clk         : line-rate clock, one edge per line
//   reset       : asynchronous active-high reset
//   vsync       : asynchronous vertical sync (active level = VS_ACTIVE)
//   q           : line index, 0 on the cycle frame_start is high
//   frame_len   : length of the last completed frame in lines
//   vs_width    : width of the last sync pulse in lines, saturating at 15
//   frame_start : one-cycle pulse per detected sync leading edge
//   locked      : high while in the LOCK state
//   err         : one-cycle pulse on frame-length mismatch or timeout
// -----------------------------------------------------------------------------
module vsync_rx
  import vsync_rx_pkg::*;
#(
  parameter logic VS_ACTIVE   = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  output logic [LINE_W-1:0] q,
  output logic [LINE_W-1:0] frame_len,
  output logic [PW_W-1:0]   vs_width,
  output logic              frame_start,
  output logic              locked,
  output logic              err
);

  localparam int MATCH_W = 8;
  localparam logic [MATCH_W-1:0] LOCK_N = MATCH_W'(LOCK_FRAMES);

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_active;
  logic w_lead;
  logic w_trail;

  vs_state_e          r_state;
  vs_state_e          w_state_nxt;
  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [LINE_W-1:0]  r_q;
  logic [LINE_W-1:0]  w_q_nxt;
  logic [LINE_W-1:0]  w_q_inc;
  logic [LINE_W-1:0]  r_frame_len;
  logic               w_len_upd;
  logic               w_err_nxt;
  logic [PW_W-1:0]    r_pw;
  logic [PW_W-1:0]    r_vs_width;
  logic               r_frame_start;
  logic               r_locked;
  logic               r_err;

  // Flops start at the inactive level so a sync already active at release
  // still produces a clean leading edge.
  sync_edge #(
    .RST_VAL(~VS_ACTIVE)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (vsync),
    .level(w_level),
    .rise (w_rise),
    .fall (w_fall)
  );

  assign w_active = (w_level == VS_ACTIVE);
  assign w_lead   = VS_ACTIVE ? w_rise : w_fall;
  assign w_trail  = VS_ACTIVE ? w_fall : w_rise;

  // q+1 is the length of the frame ending at this leading edge; outside SEARCH
  // q never exceeds 1022, so it cannot wrap.
  assign w_q_inc = r_q + 10'd1;

  // Next-state, line counter and error decode; a leading edge outranks timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_err_nxt   = 1'b0;
    w_len_upd   = 1'b0;
    w_q_nxt     = line_sat_inc(r_q);
    if (w_lead) begin
      w_q_nxt = 10'd0;
      case (r_state)
        ST_SEARCH: begin
          w_state_nxt = ST_MEASURE;
        end
        ST_MEASURE: begin
          w_len_upd   = 1'b1;
          w_match_nxt = 8'd1;
          w_state_nxt = ST_CHECK;
        end
        ST_CHECK, ST_LOCK: begin
          w_len_upd = 1'b1;
          if (w_q_inc == r_frame_len) begin
            if (r_state == ST_CHECK) begin
              w_match_nxt = r_match + 8'd1;
              if (w_match_nxt >= LOCK_N) begin
                w_state_nxt = ST_LOCK;
              end else begin
                w_state_nxt = ST_CHECK;
              end
            end else begin
              w_state_nxt = ST_LOCK;
            end
          end else begin
            w_err_nxt   = 1'b1;
            w_match_nxt = 8'd1;
            w_state_nxt = ST_CHECK;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_match_nxt = 8'd0;
        end
      endcase
    end else if ((r_state != ST_SEARCH) && (r_q >= LINE_MAX - 10'd1)) begin
      w_err_nxt   = 1'b1;
      w_state_nxt = ST_SEARCH;
      w_match_nxt = 8'd0;
      w_q_nxt     = LINE_MAX;
    end else begin
      w_err_nxt = 1'b0;
    end
  end

  // FSM state, line counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_SEARCH;
      r_match       <= 8'd0;
      r_q           <= 10'd0;
      r_frame_len   <= 10'd0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_match       <= w_match_nxt;
      r_q           <= w_q_nxt;
      r_frame_start <= w_lead;
      r_locked      <= (w_state_nxt == ST_LOCK);
      r_err         <= w_err_nxt;
      if (w_len_upd) begin
        r_frame_len <= w_q_inc;
      end
    end
  end

  // Sync pulse width: restart at 1 on the leading edge, count while active,
  // publish on the trailing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pw       <= 4'd0;
      r_vs_width <= 4'd0;
    end else begin
      if (w_lead) begin
        r_pw <= 4'd1;
      end else if (w_active) begin
        r_pw <= pw_sat_inc(r_pw);
      end
      if (w_trail) begin
        r_vs_width <= r_pw;
      end
    end
  end

  assign q           = r_q;
  assign frame_len   = r_frame_len;
  assign vs_width    = r_vs_width;
  assign frame_start = r_frame_start;
  assign locked      = r_locked;
  assign err         = r_err;

endmodule
